// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and constants for the register file write arbiter
package regfile_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rf_arb_starve_timer.sv
// rtl/rf_arb_starve_timer.sv - counts consecutive blocked MD cycles and flags the forced-grant point
module rf_arb_starve_timer #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    // Next count: clear wins, otherwise count up and saturate instead of wrapping
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (count_en && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // At zero in IDLE this already fires when MAX_WAIT is 1, so IDLE can go straight to FORCE
    assign expired = (wait_cnt_q == CNT_LIMIT);

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register file write port between WB (priority) and the mul/div unit
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_reg,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              stall_pipe,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    arb_state_e state_q;
    arb_state_e state_d;

    logic              rf_we_q;
    logic              rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [ADDR_W-1:0] rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [DATA_W-1:0] rf_wdata_d;

    logic wb_use;
    logic md_accept;
    logic blocked;
    logic expired;

    // Port ownership for this cycle; in FORCE the stalled WB instruction is ignored and re-presents later
    always_comb begin
        wb_use     = 1'b0;
        md_ready   = 1'b0;
        md_accept  = 1'b0;
        blocked    = 1'b0;
        stall_pipe = 1'b0;
        wb_use     = wb_valid && (wb_reg != ZERO_ADDR) && (state_q != FORCE);
        md_ready   = !reset && ((state_q == FORCE) || !wb_use);
        md_accept  = md_valid && md_ready;
        blocked    = md_valid && !md_ready;
        stall_pipe = (state_q == FORCE);
    end

    rf_arb_starve_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (!blocked),
        .count_en (blocked),
        .expired  (expired)
    );

    // Starvation FSM: every blocked cycle counts, expiry forces a one-cycle MD grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (blocked) begin
                    state_d = expired ? FORCE : WAIT;
                end
            end
            WAIT: begin
                if (!blocked) begin
                    state_d = IDLE;
                end else if (expired) begin
                    state_d = FORCE;
                end
            end
            FORCE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant mux: WB first, then an accepted MD result; writes to $0 never reach the port
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_use) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_reg;
            rf_wdata_d = wb_data;
        end else if (md_accept && (md_reg != ZERO_ADDR)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = md_reg;
            rf_wdata_d = md_data;
        end
    end

    // State and write-port registers; the register file samples these on the following negedge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter with a cycle-level reference model
module tb_regfile_write_arbiter;

    localparam int MW = 4;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_reg = '0;
    logic [31:0] md_data = '0;
    logic        md_ready;
    logic        stall_pipe;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int failures = 0;

    exp_t q[$];
    bit   mon_en = 1'b0;

    // reference model state
    int          run = 0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] rf_exp[32];
    logic [31:0] rf_act[32];

    // MD producer state
    bit          md_v = 1'b0;
    logic [4:0]  md_r = '0;
    logic [31:0] md_d = '0;

    regfile_write_arbiter #(
        .MAX_WAIT (MW),
        .DATA_W   (32),
        .ADDR_W   (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .md_valid   (md_valid),
        .md_reg     (md_reg),
        .md_data    (md_data),
        .md_ready   (md_ready),
        .stall_pipe (stall_pipe),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check combinational outputs against the model, push the expected write
    task automatic step(input bit rst, input bit wv, input logic [4:0] wr, input logic [31:0] wd);
        bit   force_e;
        bit   wb_use_e;
        bit   rdy_e;
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        wb_valid = wv;
        wb_reg   = wr;
        wb_data  = wd;
        md_valid = md_v;
        md_reg   = md_r;
        md_data  = md_d;
        #1;
        force_e  = (run == MW);
        wb_use_e = !force_e && wv && (wr != 5'd0);
        rdy_e    = !rst && (force_e || !wb_use_e);
        chk("md_ready", {31'd0, md_ready}, {31'd0, rdy_e});
        chk("stall_pipe", {31'd0, stall_pipe}, {31'd0, force_e});
        mon_en = 1'b1;
        if (rst) begin
            last_addr = '0;
            last_data = '0;
            e.we = 1'b0;
            run = 0;
            md_v = 1'b0;
        end else begin
            e.we = 1'b0;
            if (wb_use_e) begin
                e.we = 1'b1;
                last_addr = wr;
                last_data = wd;
            end else if (md_v && rdy_e && (md_r != 5'd0)) begin
                e.we = 1'b1;
                last_addr = md_r;
                last_data = md_d;
            end
            if (e.we) rf_exp[last_addr] = last_data;
            run = (md_v && !rdy_e) ? run + 1 : 0;
            if (md_v && rdy_e) md_v = 1'b0;
        end
        e.addr = last_addr;
        e.data = last_data;
        q.push_back(e);
    endtask

    // Monitor: registered outputs seen after each posedge are matched against the queued expectation
    always begin
        bit   en_s;
        exp_t e;
        @(posedge clk);
        en_s = mon_en;
        #3;
        if (en_s) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: got rf_we=%b expected a queued entry", rf_we);
            end else begin
                e = q.pop_front();
                chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
                chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
                chk("rf_wdata", rf_wdata, e.data);
            end
        end
    end

    // Register file image built from the DUT write port on the negedge
    always @(negedge clk) begin
        if (mon_en && rf_we === 1'b1) rf_act[rf_waddr] <= rf_wdata;
    end

    initial begin
        logic [4:0]  r;
        logic [31:0] d;
        for (int i = 0; i < 32; i++) begin
            rf_exp[i] = '0;
            rf_act[i] = '0;
        end

        // reset held with a WB write pending, then released
        repeat (3) step(1'b1, 1'b1, 5'd3, 32'h0000_0033);
        step(1'b0, 1'b1, 5'd3, 32'h0000_0033);

        // WB only, then idle
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        #1;
        chk("reg5_after_negedge", rf_act[5], 32'hDEAD_BEEF);

        // MD only
        md_v = 1'b1; md_r = 5'd8; md_d = 32'h1234_5678;
        step(1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, 1'b0, 5'd0, 32'h0);

        // WB continuously valid, MD starved until the forced grant
        md_v = 1'b1; md_r = 5'd7; md_d = 32'hCAFE_0007;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 5'd2, 32'h2000_0000 + i);
        step(1'b0, 1'b0, 5'd0, 32'h0);

        // WB to $0 alongside an MD result
        md_v = 1'b1; md_r = 5'd9; md_d = 32'h9999_0009;
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);

        // MD to $0: handshake only
        md_v = 1'b1; md_r = 5'd0; md_d = 32'h5555_AAAA;
        step(1'b0, 1'b0, 5'd0, 32'h0);

        // reset while waiting, then a fresh starvation run must take the full budget again
        md_v = 1'b1; md_r = 5'd10; md_d = 32'h0A0A_0A0A;
        step(1'b0, 1'b1, 5'd2, 32'h1);
        step(1'b0, 1'b1, 5'd2, 32'h2);
        step(1'b1, 1'b1, 5'd2, 32'h3);
        step(1'b0, 1'b0, 5'd0, 32'h0);
        md_v = 1'b1; md_r = 5'd11; md_d = 32'h0B0B_0B0B;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 5'd4, 32'h4000_0000 + i);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!md_v && $urandom_range(0, 99) < 35) begin
                md_v = 1'b1;
                md_r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                md_d = $urandom;
            end else if (md_v && $urandom_range(0, 99) < 2) begin
                md_v = 1'b0;
            end
            r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            d = $urandom;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 75, r, d);
        end

        md_v = 1'b0;
        step(1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #6;
        chk("queue_drained", q.size(), 32'd0);
        for (int i = 0; i < 32; i++) chk($sformatf("regfile[%0d]", i), rf_act[i], rf_exp[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 MIPS register file.
- Shares that port between two writers:
  - the pipeline writeback stage (WB), which has priority;
  - the multi-cycle mul/div unit (MD), which uses a valid/ready handshake.
- Guarantees MD forward progress with a starvation timer that stalls the pipeline for one cycle and grants MD.
- Sits between the WB stage, the MD unit and the register file write inputs (regWrite, writeRegister, writeData).

Parameters:
- MAX_WAIT, 4, number of consecutive blocked MD cycles tolerated before a forced grant (legal range 1..15).
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  system clock; arbiter state updates on posedge; the register file writes on the following negedge.
- reset  in  1  reset, synchronous, active-high.
- wb_valid  in  1  WB stage holds a register-writing instruction.
- wb_reg  in  ADDR_W  WB destination register.
- wb_data  in  DATA_W  WB write data.
- md_valid  in  1  MD result pending.
- md_reg  in  ADDR_W  MD destination register.
- md_data  in  DATA_W  MD result.
- md_ready  out  1  combinational; MD result accepted this cycle when md_valid && md_ready.
- stall_pipe  out  1  Moore output; high for exactly the FORCE cycle; the pipeline freezes all stages.
- rf_we  out  1  registered; drives the register file regWrite.
- rf_waddr  out  ADDR_W  registered; drives writeRegister.
- rf_wdata  out  DATA_W  registered; drives writeData.

Behaviour:
- Reset:
  - rf_we=0, rf_waddr=0, rf_wdata=0, stall_pipe=0.
  - state=IDLE, wait_cnt=0.
  - md_ready forced 0 while reset is high.
  - An MD result pending at reset is dropped (not written); the MD unit is reset by the same signal.
- Port usage:
  - wb_use = wb_valid && wb_reg!=0 && state!=FORCE.
  - Writes to $0 never use the port and are never written.
- md_ready = !reset && (state==FORCE || !wb_use).
  - An MD accept with md_reg==0 completes the handshake; rf_we stays 0.
- Registered write outputs, updated at each posedge:
  - wb_use: rf_we=1, rf_waddr/rf_wdata from wb_reg/wb_data.
  - else MD accept with md_reg!=0: rf_we=1, fields from md_reg/md_data.
  - else rf_we=0, and addr/data hold their previous values.
- Latency: an input sampled at posedge N is written to the register file at the negedge of cycle N.
- blocked = md_valid && !md_ready.
- FSM states and transitions:
  - IDLE:
    - blocked → WAIT, wait_cnt=1.
    - if MAX_WAIT==1, blocked → FORCE directly.
  - WAIT:
    - !md_valid or accepted → IDLE, wait_cnt=0.
    - blocked && wait_cnt==MAX_WAIT-1 → FORCE.
    - blocked otherwise → stay, wait_cnt+1.
  - FORCE:
    - stall_pipe=1 and md_ready=1; WB input ignored (the stalled WB instruction re-presents next cycle).
    - Always → IDLE next cycle, wait_cnt=0.
    - If md_valid dropped in FORCE, no write occurs; still → IDLE.
- Consequence: MD is blocked for at most MAX_WAIT cycles and is granted on cycle MAX_WAIT+1.
- Same-register conflict (wb_reg==md_reg, both valid): WB wins and MD waits. Ordering is guaranteed upstream by the decode interlock; the arbiter does no WAW check.
- wait_cnt saturates and never wraps; its width is $clog2(MAX_WAIT+1).

Decomposition:
- Package regfile_arb_pkg contains:
  - arb_state_e enum {IDLE, WAIT, FORCE};
  - REG_ZERO constant (5'd0);
  - default ADDR_W/DATA_W localparams.
- One sub-module, rf_arb_starve_timer:
  - inputs: clear, count_en;
  - output: expired;
  - holds wait_cnt and the compare against MAX_WAIT-1.
- Remaining arbiter: FSM, grant mux and output flops, about 150-200 lines in total.

Test Plan:
- Reset with wb_valid=1, wb_reg=3 held: rf_we=0 and md_ready=0 throughout; first posedge after reset deasserts → rf_we=1, rf_waddr=3.
- WB only, wb_reg=5, wb_data=0xDEADBEEF: register $5 reads 0xDEADBEEF after that cycle's negedge; rf_we=0 the following idle cycle.
- MD only, md_reg=8, md_data=0x12345678, wb_valid=0: md_ready=1 in the same cycle, rf_waddr=8 next posedge, no stall.
- WB continuously valid (wb_reg=2) with md_valid held, MAX_WAIT=4:
  - md_ready=0 for 4 cycles;
  - cycle 5: stall_pipe=1, md_ready=1, MD written, WB not written;
  - cycle 6: IDLE, WB written.
- wb_reg=0 with md_valid, md_reg=9 in the same cycle: MD granted immediately and $0 stays 0.
- md_reg=0 accepted: handshake completes, rf_we=0. Separately, assert reset during WAIT: state=IDLE, wait_cnt=0, no write.
